// File: rtl/cvp_boot_loader_if.sv
// Memory-port bundle between the CVP14 core, the boot loader and system memory.
// The loader takes the slave side: core strobes in, memory strobes out.
interface cvp_boot_loader_if;
    logic [15:0] CpuAddr;
    logic        CpuRD;
    logic        CpuWR;
    logic [15:0] CpuDataOut;
    logic [15:0] MemAddr;
    logic        MemRD;
    logic        MemWR;
    logic [15:0] MemDataIn;

    modport master (
        output CpuAddr, CpuRD, CpuWR, CpuDataOut,
        input  MemAddr, MemRD, MemWR, MemDataIn
    );

    modport slave (
        input  CpuAddr, CpuRD, CpuWR, CpuDataOut,
        output MemAddr, MemRD, MemWR, MemDataIn
    );
endinterface

// File: rtl/cvp_boot_loader.sv
// UART (8N1) program loader for CVP14: writes the framed image to memory, holds the core
// in reset until the checksum passes, then muxes the core onto memory. Option: LOADER_RELOAD_EN.
module cvp_boot_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              Clk1,
    input  logic              Reset_n,
    input  logic              RxD,
    cvp_boot_loader_if.slave  bus,
    output logic              CpuReset,
    output logic              Loading,
    output logic              LoadErr
);
    localparam int            CW        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_DATA_H, S_DATA_L, S_WRITE, S_CSUM, S_RUN
    } state_t;

    rx_state_t     rx_state_q;
    logic [1:0]    rx_sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic          rx_vld_q;
    logic [7:0]    rx_byte_q;
    logic          rx_in;

    state_t        state_q;
    logic [15:0]   ptr_q;
    logic [15:0]   remain_q;
    logic [7:0]    data_hi_q;
    logic [7:0]    sum_q;
    logic [15:0]   mem_addr_q;
    logic [15:0]   mem_data_q;
    logic          mem_wr_q;
    logic          cpu_reset_q;
    logic          loading_q;
    logic          load_err_q;
    logic          run;

    assign rx_in = rx_sync_q[1];

    // Receiver: every sample point is at mid-bit, counted from the detected falling edge.
    always_ff @(posedge Clk1) begin
        if (!Reset_n) begin
            rx_state_q <= R_IDLE;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_vld_q   <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], RxD};
            rx_prev_q <= rx_in;
            rx_vld_q  <= 1'b0;
            unique case (rx_state_q)
                R_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_in) rx_state_q <= R_START;
                end
                R_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_in ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                R_DATA: begin
                    if (rx_cnt_q == FULL_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_in, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                R_STOP: begin
                    if (rx_cnt_q == FULL_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= R_IDLE;
                        rx_vld_q   <= rx_in;
                        rx_byte_q  <= rx_shift_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                default: rx_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk1) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            remain_q    <= '0;
            data_hi_q   <= '0;
            sum_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wr_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            loading_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            mem_wr_q    <= 1'b0;
            // Core leaves reset one cycle after RUN is entered.
            cpu_reset_q <= (state_q != S_RUN);
            unique case (state_q)
                S_IDLE: if (rx_vld_q && rx_byte_q == SYNC_BYTE) begin
                    state_q   <= S_ADDR_H;
                    loading_q <= 1'b1;
                    sum_q     <= '0;
                end
                S_ADDR_H: if (rx_vld_q) begin
                    ptr_q[15:8] <= rx_byte_q;
                    sum_q       <= sum_q + rx_byte_q;
                    state_q     <= S_ADDR_L;
                end
                S_ADDR_L: if (rx_vld_q) begin
                    ptr_q[7:0] <= rx_byte_q;
                    sum_q      <= sum_q + rx_byte_q;
                    state_q    <= S_CNT_H;
                end
                S_CNT_H: if (rx_vld_q) begin
                    remain_q[15:8] <= rx_byte_q;
                    sum_q          <= sum_q + rx_byte_q;
                    state_q        <= S_CNT_L;
                end
                S_CNT_L: if (rx_vld_q) begin
                    remain_q[7:0] <= rx_byte_q;
                    sum_q         <= sum_q + rx_byte_q;
                    state_q       <= ({remain_q[15:8], rx_byte_q} == 16'h0000) ? S_CSUM : S_DATA_H;
                end
                S_DATA_H: if (rx_vld_q) begin
                    data_hi_q <= rx_byte_q;
                    sum_q     <= sum_q + rx_byte_q;
                    state_q   <= S_DATA_L;
                end
                S_DATA_L: if (rx_vld_q) begin
                    mem_addr_q <= ptr_q;
                    mem_data_q <= {data_hi_q, rx_byte_q};
                    mem_wr_q   <= 1'b1;
                    sum_q      <= sum_q + rx_byte_q;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    ptr_q    <= ptr_q + 16'd1;
                    remain_q <= remain_q - 16'd1;
                    state_q  <= (remain_q == 16'd1) ? S_CSUM : S_DATA_H;
                end
                S_CSUM: if (rx_vld_q) begin
                    loading_q <= 1'b0;
                    if (rx_byte_q == sum_q) begin
                        state_q    <= S_RUN;
                        load_err_q <= 1'b0;
                    end else begin
                        state_q    <= S_IDLE;
                        load_err_q <= 1'b1;
                    end
                end
                S_RUN: begin
`ifdef LOADER_RELOAD_EN
                    if (rx_vld_q && rx_byte_q == SYNC_BYTE) begin
                        state_q     <= S_ADDR_H;
                        loading_q   <= 1'b1;
                        sum_q       <= '0;
                        cpu_reset_q <= 1'b1;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign run           = (state_q == S_RUN);
    assign bus.MemAddr   = run ? bus.CpuAddr    : mem_addr_q;
    assign bus.MemRD     = run ? bus.CpuRD      : 1'b0;
    assign bus.MemWR     = run ? bus.CpuWR      : mem_wr_q;
    assign bus.MemDataIn = run ? bus.CpuDataOut : mem_data_q;
    assign CpuReset      = cpu_reset_q;
    assign Loading       = loading_q;
    assign LoadErr       = load_err_q;
endmodule
